// File: rtl/dcpu16_alu.sv
// dcpu16 execute stage: basic-op ALU producing the result word, the O register and the IFx condition flag.
// Latency: 1 cycle for all ops; DIV takes 32 busy cycles and MOD 16 busy cycles (restoring divider) when b != 0.
// Backpressure: busy holds off issue; ena/pha are ignored while the divider runs.
module dcpu16_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        pha,
    input  logic        skp,
    input  logic [3:0]  opc,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic [15:0] res,
    output logic [15:0] ovf,
    output logic        cnd,
    output logic        vld,
    output logic        busy
);

    localparam logic [3:0] OP_SET = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_MUL = 4'h4;
    localparam logic [3:0] OP_DIV = 4'h5;
    localparam logic [3:0] OP_MOD = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_AND = 4'h9;
    localparam logic [3:0] OP_BOR = 4'hA;
    localparam logic [3:0] OP_XOR = 4'hB;
    localparam logic [3:0] OP_IFE = 4'hC;
    localparam logic [3:0] OP_IFN = 4'hD;
    localparam logic [3:0] OP_IFG = 4'hE;
    localparam logic [3:0] OP_IFB = 4'hF;

    // Issue qualification: a squashed or non-basic op is accepted but has no effect.
    logic issue, live, long_op;
    assign issue   = ena & pha & ~busy;
    assign live    = issue & ~skp & (opc != 4'h0);
    assign long_op = ((opc == OP_DIV) || (opc == OP_MOD)) && (opb != 16'h0);

    // Single-cycle result datapath; defaults keep res/ovf unchanged and cnd set.
    logic [15:0] s_res, s_ovf;
    logic        s_cnd;
    logic [31:0] mul_p, shl_p, shr_p;
    logic [16:0] sum_p, dif_p;
    logic        big_sh;
    always_comb begin
        s_res  = res;
        s_ovf  = ovf;
        s_cnd  = 1'b1;
        mul_p  = {16'h0, opa} * {16'h0, opb};
        shl_p  = {16'h0, opa} << opb[4:0];
        shr_p  = {opa, 16'h0} >> opb[4:0];
        sum_p  = {1'b0, opa} + {1'b0, opb};
        dif_p  = {1'b0, opa} - {1'b0, opb};
        big_sh = |opb[15:5];
        case (opc)
            OP_SET: s_res = opb;
            OP_ADD: begin
                s_res = sum_p[15:0];
                s_ovf = sum_p[16] ? 16'h0001 : 16'h0000;
            end
            OP_SUB: begin
                s_res = dif_p[15:0];
                s_ovf = dif_p[16] ? 16'hFFFF : 16'h0000;
            end
            OP_MUL: begin
                s_res = mul_p[15:0];
                s_ovf = mul_p[31:16];
            end
            // Only reached here with b == 0; nonzero divisors go to the iterative divider.
            OP_DIV: begin
                s_res = 16'h0;
                s_ovf = 16'h0;
            end
            OP_MOD: s_res = 16'h0;
            OP_SHL: begin
                s_res = big_sh ? 16'h0 : shl_p[15:0];
                s_ovf = big_sh ? 16'h0 : shl_p[31:16];
            end
            OP_SHR: begin
                s_res = big_sh ? 16'h0 : shr_p[31:16];
                s_ovf = big_sh ? 16'h0 : shr_p[15:0];
            end
            OP_AND: s_res = opa & opb;
            OP_BOR: s_res = opa | opb;
            OP_XOR: s_res = opa ^ opb;
            OP_IFE: begin
                s_res = opa;
                s_cnd = (opa == opb);
            end
            OP_IFN: begin
                s_res = opa;
                s_cnd = (opa != opb);
            end
            OP_IFG: begin
                s_res = opa;
                s_cnd = (opa > opb);
            end
            OP_IFB: begin
                s_res = opa;
                s_cnd = ((opa & opb) != 16'h0);
            end
            default: ;
        endcase
    end

    // Divider state: dvd shifts the dividend out at the top while quotient bits enter at the bottom.
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] rem;
    logic [4:0]  cnt;
    logic        mod_op;

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    logic [16:0] shf, sub;
    logic        ge;
    logic [15:0] rem_n;
    logic [31:0] dvd_n;
    always_comb begin
        shf   = {rem, dvd[31]};
        sub   = shf - {1'b0, dvs};
        ge    = (shf >= {1'b0, dvs});
        rem_n = ge ? sub[15:0] : shf[15:0];
        dvd_n = {dvd[30:0], ge};
    end

    // Result registers, divider sequencing and the one-cycle vld pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res    <= 16'h0;
            ovf    <= 16'h0;
            cnd    <= 1'b1;
            vld    <= 1'b0;
            busy   <= 1'b0;
            dvd    <= 32'h0;
            dvs    <= 16'h0;
            rem    <= 16'h0;
            cnt    <= 5'h0;
            mod_op <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (busy) begin
                dvd <= dvd_n;
                rem <= rem_n;
                cnt <= cnt - 5'd1;
                if (cnt == 5'd0) begin
                    busy <= 1'b0;
                    vld  <= 1'b1;
                    if (mod_op) begin
                        res <= rem_n;
                    end else begin
                        res <= dvd_n[31:16];
                        ovf <= dvd_n[15:0];
                    end
                end
            end else if (live) begin
                cnd <= s_cnd;
                if (long_op) begin
                    busy   <= 1'b1;
                    dvd    <= {opa, 16'h0};
                    dvs    <= opb;
                    rem    <= 16'h0;
                    cnt    <= (opc == OP_DIV) ? 5'd31 : 5'd15;
                    mod_op <= (opc == OP_MOD);
                end else begin
                    res <= s_res;
                    ovf <= s_ovf;
                    vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcpu16_alu.sv
// Directed testbench for dcpu16_alu.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
// Each scenario task carries its own inline comparisons against hand-computed values.
module tb_dcpu16_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena, pha, skp;
    logic [3:0]  opc;
    logic [15:0] opa, opb;
    logic [15:0] res, ovf;
    logic        cnd, vld, busy;

    int tests = 0;
    int fails = 0;

    dcpu16_alu dut (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .pha  (pha),
        .skp  (skp),
        .opc  (opc),
        .opa  (opa),
        .opb  (opb),
        .res  (res),
        .ovf  (ovf),
        .cnd  (cnd),
        .vld  (vld),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Present one instruction for a single issue edge, then drop the strobes.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic sk);
        @(negedge clk);
        ena = 1'b1; pha = 1'b1; skp = sk; opc = op; opa = a; opb = b;
        @(posedge clk);
        #1;
        ena = 1'b0; pha = 1'b0; skp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ena = 1'b1; pha = 1'b1; skp = 1'b0;
        opc = 4'($urandom); opa = 16'($urandom); opb = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        tests++; if (res !== 16'h0) begin fails++; $display("FAIL reset_res got %h exp 0000", res); end
        tests++; if (ovf !== 16'h0) begin fails++; $display("FAIL reset_ovf got %h exp 0000", ovf); end
        tests++; if (cnd !== 1'b1) begin fails++; $display("FAIL reset_cnd got %b exp 1", cnd); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (vld !== 1'b0) begin fails++; $display("FAIL reset_vld got %b exp 0", vld); end
        @(negedge clk);
        ena = 1'b0; pha = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_add();
        issue(4'h2, 16'hFFFF, 16'h0001, 1'b0);
        tests++; if (res !== 16'h0000) begin fails++; $display("FAIL add_res got %h exp 0000", res); end
        tests++; if (ovf !== 16'h0001) begin fails++; $display("FAIL add_ovf got %h exp 0001", ovf); end
        tests++; if (vld !== 1'b1) begin fails++; $display("FAIL add_vld got %b exp 1", vld); end
        @(posedge clk); #1;
        tests++; if (vld !== 1'b0) begin fails++; $display("FAIL add_vld_pulse got %b exp 0", vld); end
        issue(4'h3, 16'h0001, 16'h0002, 1'b0);
        tests++; if (res !== 16'hFFFF || ovf !== 16'hFFFF) begin fails++; $display("FAIL sub_borrow got %h/%h exp ffff/ffff", res, ovf); end
    endtask

    task automatic test_mul_shift();
        issue(4'h4, 16'h1234, 16'h0100, 1'b0);
        tests++; if (res !== 16'h3400 || ovf !== 16'h0012) begin fails++; $display("FAIL mul got %h/%h exp 3400/0012", res, ovf); end
        issue(4'h8, 16'h8001, 16'h0004, 1'b0);
        tests++; if (res !== 16'h0800 || ovf !== 16'h1000) begin fails++; $display("FAIL shr got %h/%h exp 0800/1000", res, ovf); end
        issue(4'h7, 16'h8003, 16'h0004, 1'b0);
        tests++; if (res !== 16'h0030 || ovf !== 16'h0008) begin fails++; $display("FAIL shl got %h/%h exp 0030/0008", res, ovf); end
        issue(4'h7, 16'h0001, 16'd40, 1'b0);
        tests++; if (res !== 16'h0000 || ovf !== 16'h0000) begin fails++; $display("FAIL shl_big got %h/%h exp 0000/0000", res, ovf); end
    endtask

    task automatic test_div();
        int n;
        logic held;
        issue(4'h5, 16'd7, 16'd2, 1'b0);
        // Keep trying to issue a SET during the divide; it must be ignored.
        ena = 1'b1; pha = 1'b1; opc = 4'h1; opa = 16'h0; opb = 16'hBEEF;
        n = 0;
        held = 1'b1;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (res !== 16'h0000 || vld !== 1'b0) held = 1'b0;
            @(posedge clk); #1;
        end
        ena = 1'b0; pha = 1'b0;
        tests++; if (n != 32) begin fails++; $display("FAIL div_busy_cycles got %0d exp 32", n); end
        tests++; if (held !== 1'b1) begin fails++; $display("FAIL div_hold got %b exp 1", held); end
        tests++; if (res !== 16'h0003 || ovf !== 16'h8000) begin fails++; $display("FAIL div_result got %h/%h exp 0003/8000", res, ovf); end
        tests++; if (vld !== 1'b1) begin fails++; $display("FAIL div_vld got %b exp 1", vld); end
        @(posedge clk); #1;
        tests++; if (vld !== 1'b0 || res !== 16'h0003) begin fails++; $display("FAIL div_after got vld %b res %h exp 0/0003", vld, res); end
        issue(4'h5, 16'd9, 16'd0, 1'b0);
        tests++; if (res !== 16'h0 || ovf !== 16'h0 || vld !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL div_zero got %h/%h vld %b busy %b exp 0000/0000 1 0", res, ovf, vld, busy);
        end
    endtask

    task automatic test_mod();
        int n;
        issue(4'h4, 16'hAAAA, 16'h8000, 1'b0);
        tests++; if (ovf !== 16'h5555) begin fails++; $display("FAIL mod_preload got %h exp 5555", ovf); end
        issue(4'h6, 16'd10, 16'd3, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        tests++; if (n != 16) begin fails++; $display("FAIL mod_busy_cycles got %0d exp 16", n); end
        tests++; if (res !== 16'h0001 || ovf !== 16'h5555 || vld !== 1'b1) begin
            fails++; $display("FAIL mod_result got %h/%h vld %b exp 0001/5555 1", res, ovf, vld);
        end
        issue(4'h6, 16'd10, 16'd0, 1'b0);
        tests++; if (res !== 16'h0 || ovf !== 16'h5555 || busy !== 1'b0) begin fails++; $display("FAIL mod_zero got %h/%h busy %b exp 0000/5555 0", res, ovf, busy); end
    endtask

    task automatic test_ifx();
        issue(4'hE, 16'd5, 16'd3, 1'b0);
        tests++; if (cnd !== 1'b1 || res !== 16'd5) begin fails++; $display("FAIL ifg got cnd %b res %h exp 1/0005", cnd, res); end
        issue(4'hB, 16'h00F0, 16'h0F00, 1'b0);
        tests++; if (res !== 16'h0FF0) begin fails++; $display("FAIL xor got %h exp 0ff0", res); end
        issue(4'hF, 16'h00F0, 16'h0F00, 1'b0);
        tests++; if (cnd !== 1'b0 || res !== 16'h00F0 || ovf !== 16'h5555) begin
            fails++; $display("FAIL ifb got cnd %b res %h ovf %h exp 0/00f0/5555", cnd, res, ovf);
        end
        issue(4'h1, 16'h0000, 16'h1234, 1'b0);
        tests++; if (cnd !== 1'b1 || res !== 16'h1234) begin fails++; $display("FAIL set got cnd %b res %h exp 1/1234", cnd, res); end
        issue(4'hC, 16'd4, 16'd5, 1'b0);
        tests++; if (cnd !== 1'b0) begin fails++; $display("FAIL ife got %b exp 0", cnd); end
        issue(4'hD, 16'd7, 16'd7, 1'b0);
        tests++; if (cnd !== 1'b0 || res !== 16'd7) begin fails++; $display("FAIL ifn got cnd %b res %h exp 0/0007", cnd, res); end
        issue(4'h1, 16'h0000, 16'h1234, 1'b0);
        tests++; if (cnd !== 1'b1) begin fails++; $display("FAIL set_cnd got %b exp 1", cnd); end
    endtask

    task automatic test_skip();
        issue(4'h2, 16'h0001, 16'h0001, 1'b1);
        tests++; if (vld !== 1'b0 || res !== 16'h1234 || ovf !== 16'h5555) begin
            fails++; $display("FAIL skip got vld %b res %h ovf %h exp 0/1234/5555", vld, res, ovf);
        end
        issue(4'hC, 16'h0001, 16'h0002, 1'b1);
        tests++; if (cnd !== 1'b1 || vld !== 1'b0) begin fails++; $display("FAIL skip_if got cnd %b vld %b exp 1/0", cnd, vld); end
        issue(4'h0, 16'h0001, 16'h0001, 1'b0);
        tests++; if (vld !== 1'b0 || res !== 16'h1234) begin fails++; $display("FAIL nonbasic got vld %b res %h exp 0/1234", vld, res); end
        issue(4'h5, 16'd100, 16'd7, 1'b1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL skip_div got busy %b exp 0", busy); end
    endtask

    task automatic test_reset_mid_div();
        issue(4'h5, 16'd100, 16'd7, 1'b0);
        repeat (9) @(posedge clk);
        #3;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL middiv_busy got %b exp 1", busy); end
        rst = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || res !== 16'h0 || ovf !== 16'h0 || cnd !== 1'b1 || vld !== 1'b0) begin
            fails++; $display("FAIL middiv_reset got busy %b res %h ovf %h cnd %b vld %b exp 0/0000/0000/1/0", busy, res, ovf, cnd, vld);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(4'h2, 16'd2, 16'd3, 1'b0);
        tests++; if (res !== 16'd5 || ovf !== 16'h0 || vld !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL post_reset_add got %h/%h vld %b busy %b exp 0005/0000 1 0", res, ovf, vld, busy);
        end
        repeat (40) @(posedge clk);
        #1;
        tests++; if (res !== 16'd5 || ovf !== 16'h0) begin fails++; $display("FAIL aborted_div_trace got %h/%h exp 0005/0000", res, ovf); end
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; pha = 1'b0; skp = 1'b0;
        opc = 4'h0; opa = 16'h0; opb = 16'h0;
        test_reset();
        test_add();
        test_mul_shift();
        test_div();
        test_mod();
        test_ifx();
        test_skip();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcpu16_alu.md
Name: dcpu16_alu

Overview:
Execute stage directly downstream of the dcpu16 control/decode stage. Takes the registered opcode and the two fetched operand values, and produces the result word, the overflow (O) register and the IFx condition flag. All basic ops are single-cycle except DIV/MOD, which use an iterative restoring divider and hold the pipeline through busy.

Parameters:
None (16-bit datapath fixed by the ISA).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
ena  in  1  pipeline advance strobe from control stage
pha  in  1  control phase; issue only when pha=1
skp  in  1  squash current instruction
opc  in  4  basic opcode
opa  in  16  operand A value
opb  in  16  operand B value
res  out  16  result word (write-back data)
ovf  out  16  O register
cnd  out  1  condition flag: 1 = execute next instruction
vld  out  1  one-cycle pulse: res/ovf updated this cycle
busy  out  1  divider running; control must fold into stall

Behaviour:
- Reset (rst=0, async): res=0, ovf=0, cnd=1, vld=0, busy=0, divider state cleared. Applies mid-divide; the aborted op leaves no trace.
- Issue edge = rising clk with ena=1, pha=1, busy=0. The edge captures opc/opa/opb. ena/pha are ignored while busy=1 (no second issue).
- vld defaults to 0 every cycle. It is 1 only in the cycle after a result-landing edge.
- skp=1 at issue, or opc=0 (non-basic): no change to res/ovf/cnd, no vld, no busy.
- Single-cycle ops: res/ovf/cnd are registered at the issue edge and vld=1 the next cycle. Arithmetic is unsigned and mod 2^16 unless stated.
  - 1 SET: res=b
  - 2 ADD: res=a+b; ovf=0x0001 on carry-out, else 0
  - 3 SUB: res=a-b; ovf=0xFFFF on borrow, else 0
  - 4 MUL: P=a*b (32-bit); res=P[15:0], ovf=P[31:16]
  - 7 SHL: S={16'h0,a}<<b; res=S[15:0], ovf=S[31:16]; b>31 gives both 0
  - 8 SHR: res=a>>b; ovf=({a,16'h0}>>b)[15:0]; b>31 gives both 0
  - 9 AND, A BOR, B XOR: res=a op b
  - C IFE cnd=(a==b); D IFN cnd=(a!=b); E IFG cnd=(a>b) unsigned; F IFB cnd=((a&b)!=0). For C–F, res=a.
  - ovf is unchanged for SET, AND, BOR, XOR, MOD and IFx. cnd is set to 1 for every non-IF op.
- DIV (5) / MOD (6) with b=0: single-cycle; res=0; DIV also sets ovf=0, MOD leaves ovf unchanged.
- DIV with b!=0:
  - busy=1 from the issue edge for exactly 32 cycles. One restoring iteration per clk, independent of ena.
  - Dividend is {a,16'h0} (32-bit); quotient Q gives res=Q[31:16] (=a/b) and ovf=Q[15:0].
  - The 32nd iteration edge writes res/ovf, clears busy and gives vld=1 the next cycle.
- MOD with b!=0: busy=1 for exactly 16 cycles with dividend a; res=a%b; ovf unchanged.
- The first issue is accepted on the edge after busy falls, if ena&pha are high.

Test Plan:
- Reset: hold rst=0 with random inputs -> res=0, ovf=0, cnd=1, busy=0, vld=0; release, then ADD a=0xFFFF b=0x0001 -> next cycle res=0x0000, ovf=0x0001, vld=1.
- MUL a=0x1234 b=0x0100 -> res=0x3400, ovf=0x0012. SHR a=0x8001 b=4 -> res=0x0800, ovf=0x1000. SHL a=0x0001 b=40 -> res=0, ovf=0.
- DIV a=7 b=2 -> busy high exactly 32 cycles, then res=0x0003, ovf=0x8000, one vld pulse. Issue attempts during busy are ignored (res unchanged until the divide completes). DIV a=9 b=0 -> res=0, ovf=0 immediately, busy never set.
- MOD a=10 b=3 with ovf preloaded 0x5555 -> busy 16 cycles, res=0x0001, ovf still 0x5555.
- IFG a=5 b=3 -> cnd=1. IFB a=0x00F0 b=0x0F00 -> cnd=0. Following SET b=0x1234 -> cnd=1, res=0x1234. Issue with skp=1 or opc=0 -> outputs unchanged, no vld.
- Assert rst=0 in cycle 10 of a DIV -> busy=0 and all outputs reset immediately (async). A new ADD after release completes normally.
